// File: rtl/sflash_pkg.sv
// ---- sflash_pkg: shared format codes, arbiter state encodings and port ids ----
// ---- rev 1.0 ----
`default_nettype none

package sflash_pkg;

  localparam logic [2:0] FMT_END = 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_CLOSE = 2'd2
  } state_t;

  localparam logic WHO_A = 1'b0;
  localparam logic WHO_B = 1'b1;

endpackage

`default_nettype wire

// File: rtl/flash_arb.sv
// ---- flash_arb: per-transaction two-port arbiter in front of the sflash engine ----
// ---- rev 1.0 ----
`default_nettype none

module flash_arb
  import sflash_pkg::*;
#(
  parameter int PRIORITY = 1,
  parameter int HOLD_W   = 12,
  parameter int HOLD_MAX = 4000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  output logic       a_gnt,
  input  logic       a_wr,
  input  logic [7:0] a_din,
  input  logic [2:0] a_fmt,
  output logic       a_ready,
  input  logic       b_req,
  output logic       b_gnt,
  input  logic       b_wr,
  input  logic [7:0] b_din,
  input  logic [2:0] b_fmt,
  output logic       b_ready,
  input  logic       f_ready,
  output logic       f_wr,
  output logic       f_who,
  output logic [7:0] f_dout,
  output logic [2:0] f_format,
  output logic       abort
);

  localparam logic [HOLD_W-1:0] WD_TRIP = HOLD_W'(HOLD_MAX - 1);
  localparam logic [HOLD_W-1:0] WD_SAT  = '1;

  state_t            state;
  logic              owner;
  logic              last;
  logic              rearm_a;
  logic              rearm_b;
  logic [HOLD_W-1:0] wd;

  logic       own_req;
  logic       own_wr;
  logic [7:0] own_din;
  logic [2:0] own_fmt;
  logic       accept;
  logic       elig_a;
  logic       elig_b;
  logic       pick_b;
  logic       wd_trip;

  assign own_req = (owner == WHO_B) ? b_req : a_req;
  assign own_wr  = (owner == WHO_B) ? b_wr  : a_wr;
  assign own_din = (owner == WHO_B) ? b_din : a_din;
  assign own_fmt = (owner == WHO_B) ? b_fmt : a_fmt;
  assign accept  = (state == ST_BUSY) && own_wr && f_ready;

  assign elig_a = a_req & rearm_a;
  assign elig_b = b_req & rearm_b;
  // B wins alone, or on a round-robin tie when A took the previous grant.
  assign pick_b = elig_b && (!elig_a || ((PRIORITY == 0) && (last == WHO_A)));

  // Trips on the edge that would make the idle count reach HOLD_MAX.
  assign wd_trip = (HOLD_MAX != 0) && (wd == WD_TRIP) && !accept;

  assign a_ready = f_ready & a_gnt;
  assign b_ready = f_ready & b_gnt;
  assign f_who   = owner;

  always_comb begin
    f_wr     = 1'b0;
    f_dout   = 8'd0;
    f_format = FMT_END;
    case (state)
      ST_BUSY: begin
        f_wr     = accept;
        f_dout   = own_din;
        f_format = own_fmt;
      end
      ST_CLOSE: f_wr = f_ready;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      owner   <= WHO_A;
      last    <= WHO_B;
      a_gnt   <= 1'b0;
      b_gnt   <= 1'b0;
      rearm_a <= 1'b1;
      rearm_b <= 1'b1;
      wd      <= '0;
      abort   <= 1'b0;
    end else begin
      abort <= 1'b0;
      if (!a_req) rearm_a <= 1'b1;
      if (!b_req) rearm_b <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (f_ready && (elig_a || elig_b)) begin
            owner <= pick_b;
            last  <= pick_b;
            a_gnt <= !pick_b;
            b_gnt <= pick_b;
            wd    <= '0;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (accept)            wd <= '0;
          else if (wd != WD_SAT) wd <= wd + 1'b1;

          if (!own_req) begin
            a_gnt <= 1'b0;
            b_gnt <= 1'b0;
            state <= ST_CLOSE;
          end else if (wd_trip) begin
            a_gnt <= 1'b0;
            b_gnt <= 1'b0;
            abort <= 1'b1;
            if (owner == WHO_B) rearm_b <= 1'b0;
            else                rearm_a <= 1'b0;
            state <= ST_CLOSE;
          end
        end
        ST_CLOSE: begin
          if (f_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_flash_arb.sv
// ---- tb_flash_arb: scoreboard bench for flash_arb (priority and round-robin instances) ----
// ---- rev 1.0 ----
`default_nettype none

module tb_flash_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, f_ready;
  logic       a_req, a_wr, b_req, b_wr;
  logic [7:0] a_din, b_din;
  logic [2:0] a_fmt, b_fmt;
  logic       a_gnt, a_ready, b_gnt, b_ready, f_wr, f_who, abort;
  logic [7:0] f_dout;
  logic [2:0] f_format;

  logic       rr_a_req, rr_b_req;
  logic       rr_a_gnt, rr_a_ready, rr_b_gnt, rr_b_ready, rr_f_wr, rr_f_who, rr_abort;
  logic [7:0] rr_f_dout;
  logic [2:0] rr_f_format;

  flash_arb #(.PRIORITY(1), .HOLD_W(12), .HOLD_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_gnt(a_gnt), .a_wr(a_wr), .a_din(a_din), .a_fmt(a_fmt), .a_ready(a_ready),
    .b_req(b_req), .b_gnt(b_gnt), .b_wr(b_wr), .b_din(b_din), .b_fmt(b_fmt), .b_ready(b_ready),
    .f_ready(f_ready), .f_wr(f_wr), .f_who(f_who), .f_dout(f_dout), .f_format(f_format),
    .abort(abort)
  );

  flash_arb #(.PRIORITY(0), .HOLD_W(12), .HOLD_MAX(8)) dut_rr (
    .clk(clk), .rst(rst),
    .a_req(rr_a_req), .a_gnt(rr_a_gnt), .a_wr(1'b0), .a_din(8'd0), .a_fmt(3'd0), .a_ready(rr_a_ready),
    .b_req(rr_b_req), .b_gnt(rr_b_gnt), .b_wr(1'b0), .b_din(8'd0), .b_fmt(3'd0), .b_ready(rr_b_ready),
    .f_ready(f_ready), .f_wr(rr_f_wr), .f_who(rr_f_who), .f_dout(rr_f_dout), .f_format(rr_f_format),
    .abort(rr_abort)
  );

  // Expected sflash strobes as {who, format, byte}.
  logic [11:0] exp_q[$];
  logic [11:0] rr_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_abort = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (abort === 1'b1) n_abort++;
    if (f_wr === 1'b1) begin
      if (exp_q.size() == 0) check("spurious_f_wr", {31'd0, f_wr}, 32'd0);
      else check("f_byte", {20'd0, f_who, f_format, f_dout}, {20'd0, exp_q.pop_front()});
    end
    if (rr_f_wr === 1'b1) begin
      if (rr_q.size() == 0) check("rr_spurious_f_wr", {31'd0, rr_f_wr}, 32'd0);
      else check("rr_f_byte", {20'd0, rr_f_who, rr_f_format, rr_f_dout}, {20'd0, rr_q.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; f_ready = 1'b1;
    a_req = 0; a_wr = 0; a_din = 0; a_fmt = 0;
    b_req = 0; b_wr = 0; b_din = 0; b_fmt = 0;
    rr_a_req = 0; rr_b_req = 0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic send_a(input logic [7:0] d, input logic [2:0] fmt);
    check("a_ready", {31'd0, a_ready}, 32'd1);
    a_wr = 1'b1; a_din = d; a_fmt = fmt;
    exp_q.push_back({1'b0, fmt, d});
    tick();
    a_wr = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d, input logic [2:0] fmt);
    check("b_ready", {31'd0, b_ready}, 32'd1);
    b_wr = 1'b1; b_din = d; b_fmt = fmt;
    exp_q.push_back({1'b1, fmt, d});
    tick();
    b_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  gcnt;
    bit  done;
    bit  regr;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_a_gnt", {31'd0, a_gnt}, 32'd0);
    check("rst_b_gnt", {31'd0, b_gnt}, 32'd0);
    check("rst_f_wr", {31'd0, f_wr}, 32'd0);
    check("rst_f_dout", {24'd0, f_dout}, 32'd0);
    check("rst_f_format", {29'd0, f_format}, 32'd0);
    check("rst_f_who", {31'd0, f_who}, 32'd0);
    check("rst_abort", {31'd0, abort}, 32'd0);

    // Single A transaction
    tick();
    a_req = 1'b1;
    @(negedge clk);
    check("t1_gnt_before_edge", {31'd0, a_gnt}, 32'd0);
    tick();
    check("t1_a_gnt", {31'd0, a_gnt}, 32'd1);
    check("t1_b_gnt", {31'd0, b_gnt}, 32'd0);
    send_a(8'h0B, 3'd1);
    send_a(8'h00, 3'd1);
    send_a(8'h10, 3'd1);
    a_req = 1'b0;
    exp_q.push_back(12'h000);
    repeat (3) tick();
    check("t1_a_gnt_released", {31'd0, a_gnt}, 32'd0);
    check("t1_queue_drained", exp_q.size(), 32'd0);

    // Fixed priority: A wins every tie
    do_reset();
    a_req = 1'b1; b_req = 1'b1;
    for (int r = 0; r < 4; r++) begin
      tick();
      check("t2_prio_a_gnt", {31'd0, a_gnt}, 32'd1);
      check("t2_prio_b_gnt", {31'd0, b_gnt}, 32'd0);
      a_req = 1'b0;
      exp_q.push_back(12'h000);
      tick();
      a_req = 1'b1;
      tick();
    end
    a_req = 1'b0; b_req = 1'b0;
    repeat (3) tick();
    check("t2_prio_queue_drained", exp_q.size(), 32'd0);

    // Round-robin: A,B,A,B on repeated ties
    do_reset();
    rr_a_req = 1'b1; rr_b_req = 1'b1;
    for (int r = 0; r < 4; r++) begin
      tick();
      check("t2_rr_a_gnt", {31'd0, rr_a_gnt}, (r % 2 == 0) ? 32'd1 : 32'd0);
      check("t2_rr_b_gnt", {31'd0, rr_b_gnt}, (r % 2 == 0) ? 32'd0 : 32'd1);
      if (r % 2 == 0) rr_a_req = 1'b0; else rr_b_req = 1'b0;
      rr_q.push_back((r % 2 == 0) ? 12'h000 : 12'h800);
      tick();
      rr_a_req = 1'b1; rr_b_req = 1'b1;
      tick();
    end
    rr_a_req = 1'b0; rr_b_req = 1'b0;
    repeat (3) tick();
    check("t2_rr_queue_drained", rr_q.size(), 32'd0);

    // B strobes while A owns are ignored
    do_reset();
    a_req = 1'b1;
    tick();
    b_req = 1'b1; b_wr = 1'b1; b_din = 8'hFF; b_fmt = 3'd7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_b_ready", {31'd0, b_ready}, 32'd0);
      check("t3_f_dout_not_ff", {31'd0, (f_dout == 8'hFF)}, 32'd0);
      tick();
    end
    send_a(8'h55, 3'd2);
    a_req = 1'b0; b_req = 1'b0; b_wr = 1'b0;
    exp_q.push_back(12'h000);
    repeat (3) tick();
    check("t3_queue_drained", exp_q.size(), 32'd0);

    // Watchdog forced release, no regrant until req drops
    do_reset();
    exp_q.push_back(12'h000);
    a_req = 1'b1;
    tick();
    n_abort = 0;
    gcnt = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (a_gnt) gcnt++;
      if (abort) done = 1'b1;
    end
    check("t4_abort_seen", {31'd0, done}, 32'd1);
    check("t4_idle_cycles_to_abort", gcnt, 32'd8);
    regr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      regr = regr | a_gnt;
    end
    check("t4_no_regrant_while_held", {31'd0, regr}, 32'd0);
    check("t4_abort_pulses", n_abort, 32'd1);
    a_req = 1'b0;
    tick();
    a_req = 1'b1;
    tick();
    check("t4_regrant_after_drop", {31'd0, a_gnt}, 32'd1);
    a_req = 1'b0;
    exp_q.push_back(12'h000);
    repeat (3) tick();
    check("t4_queue_drained", exp_q.size(), 32'd0);

    // f_ready stall: held strobe goes out exactly once
    do_reset();
    a_req = 1'b1;
    tick();
    f_ready = 1'b0; a_wr = 1'b1; a_din = 8'hA5; a_fmt = 3'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_stall_f_wr", {31'd0, f_wr}, 32'd0);
      check("t5_stall_a_ready", {31'd0, a_ready}, 32'd0);
      tick();
    end
    exp_q.push_back({1'b0, 3'd3, 8'hA5});
    f_ready = 1'b1;
    tick();
    a_wr = 1'b0;
    check("t5_one_byte_sent", exp_q.size(), 32'd0);
    a_req = 1'b0;
    exp_q.push_back(12'h000);
    repeat (3) tick();
    check("t5_queue_drained", exp_q.size(), 32'd0);

    // Reset mid-transaction: no END byte, then B granted normally
    do_reset();
    a_req = 1'b1;
    tick();
    send_a(8'h11, 3'd1);
    send_a(8'h22, 3'd1);
    rst = 1'b1; a_req = 1'b0;
    tick();
    check("t6_a_gnt", {31'd0, a_gnt}, 32'd0);
    check("t6_b_gnt", {31'd0, b_gnt}, 32'd0);
    check("t6_f_wr", {31'd0, f_wr}, 32'd0);
    check("t6_f_dout", {24'd0, f_dout}, 32'd0);
    check("t6_f_format", {29'd0, f_format}, 32'd0);
    check("t6_f_who", {31'd0, f_who}, 32'd0);
    check("t6_abort", {31'd0, abort}, 32'd0);
    rst = 1'b0; b_req = 1'b1;
    tick();
    check("t6_b_gnt_after_rst", {31'd0, b_gnt}, 32'd1);
    check("t6_f_who_b", {31'd0, f_who}, 32'd1);
    send_b(8'h33, 3'd4);
    b_req = 1'b0;
    exp_q.push_back(12'h800);
    repeat (3) tick();
    check("t6_queue_drained", exp_q.size(), 32'd0);
    check("rr_queue_final", rr_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
